// File: rtl/tluh_device_adapter.sv
// TL-UH device adapter: turns host channel A into single-port memory requests and builds channel D responses.
// Optional request legality checks are compiled in with `define TLUH_DEV_ERR_CHECK_EN.
package tluh_pkg;
    parameter int TL_AW  = 32;
    parameter int TL_DW  = 32;
    parameter int TL_DBW = TL_DW / 8;
    parameter int TL_SZW = 3;
    parameter int TL_AIW = 8;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] ArithmeticData = 3'h2;
    localparam logic [2:0] LogicalData    = 3'h3;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] Intent         = 3'h5;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tluh_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tluh_d2h_t;
endpackage

// Handshakes: a beat moves on A when a_valid && a_ready at clk_i, on D when d_valid && d_ready,
// on the memory port when req_o && gnt_i; a valid side holds its payload stable until accepted.
module tluh_device_adapter
    import tluh_pkg::*;
#(
    parameter int SramAw = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  tluh_pkg::tluh_h2d_t  tl_d_c_a,
    output tluh_pkg::tluh_d2h_t  tl_d_c_d,
    output logic                 req_o,
    output logic                 we_o,
    output logic [SramAw-1:0]    addr_o,
    output logic [TL_DW-1:0]     wdata_o,
    output logic [TL_DBW-1:0]    be_o,
    input  logic                 gnt_i,
    input  logic                 rvalid_i,
    input  logic [TL_DW-1:0]     rdata_i,
    input  logic                 rerror_i,
    output logic [2:0]           state_o
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] PUT2    = 3'd2;
    localparam logic [2:0] WAIT_RD = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;
    localparam logic [2:0] ERR     = 3'd5;

    logic [2:0]        state_q, op_q;
    logic [TL_SZW-1:0] size_q;
    logic [TL_AIW-1:0] source_q;
    logic [SramAw-1:0] addr_q;
    logic [TL_DBW-1:0] mask_q;
    logic [TL_DW-1:0]  data_q;
    logic              two_q, beat_q, resp_idx_q, put_err_q, err_q, drain_q;
    logic [1:0]        rd_cnt_q;
    logic [TL_DW-1:0]  rbuf_q [2];
    logic              rerr_q [2];

    tluh_h2d_t a;
    assign a = tl_d_c_a;

    logic a_is_get, a_is_put, a_has_data, a_two, a_bad_chk, a_bad;
    assign a_is_get   = (a.a_opcode == Get);
    assign a_is_put   = (a.a_opcode == PutFullData) || (a.a_opcode == PutPartialData);
    assign a_has_data = a_is_put || (a.a_opcode == ArithmeticData) || (a.a_opcode == LogicalData);
    // Sizes above 3 are folded onto the 2-beat case.
    assign a_two      = (a.a_size >= 3'd3);
`ifdef TLUH_DEV_ERR_CHECK_EN
    assign a_bad_chk = (a.a_size > 3'd3)
                     || ((a.a_size == 3'd2) && (a.a_address[1:0] != 2'b00))
                     || ((a.a_size == 3'd3) && (a.a_address[2:0] != 3'b000))
                     || ((a.a_opcode == PutFullData) && (a.a_mask != '1));
`else
    assign a_bad_chk = 1'b0;
`endif
    assign a_bad = !(a_is_get || a_is_put) || a_bad_chk;

    logic unused_a;
    assign unused_a = ^{a.a_param, a.a_address};

    logic       is_get_q, is_put_q, resp_data, last_resp, rd_take;
    logic [1:0] n_beats, rd_cnt_nxt;
    assign is_get_q   = (op_q == Get);
    assign is_put_q   = (op_q == PutFullData) || (op_q == PutPartialData);
    assign resp_data  = is_get_q || (op_q == ArithmeticData) || (op_q == LogicalData);
    assign last_resp  = (resp_idx_q == (resp_data && two_q));
    assign n_beats    = two_q ? 2'd2 : 2'd1;
    // Read returns are accepted as soon as the first read is granted, even while beat 1 is still issuing.
    assign rd_take    = ((state_q == ISSUE) || (state_q == WAIT_RD)) && is_get_q && rvalid_i
                        && (rd_cnt_q < n_beats);
    assign rd_cnt_nxt = rd_cnt_q + {1'b0, rd_take};

    assign req_o   = (state_q == ISSUE);
    assign we_o    = (state_q == ISSUE) && is_put_q;
    assign addr_o  = addr_q + SramAw'(beat_q);
    assign wdata_o = data_q;
    assign be_o    = is_put_q ? mask_q : '1;
    assign state_o = state_q;

    always_comb begin
        tl_d_c_d          = '0;
        tl_d_c_d.a_ready  = rst_ni && ((state_q == IDLE) || (state_q == PUT2) ||
                                       ((state_q == ERR) && drain_q));
        tl_d_c_d.d_valid  = (state_q == RESP);
        tl_d_c_d.d_opcode = resp_data ? AccessAckData : AccessAck;
        tl_d_c_d.d_size   = size_q;
        tl_d_c_d.d_source = source_q;
        tl_d_c_d.d_data   = (resp_data && !err_q) ? rbuf_q[resp_idx_q] : '0;
        tl_d_c_d.d_error  = err_q || (is_get_q ? rerr_q[resp_idx_q] : put_err_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            op_q       <= '0;
            size_q     <= '0;
            source_q   <= '0;
            addr_q     <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            two_q      <= 1'b0;
            beat_q     <= 1'b0;
            resp_idx_q <= 1'b0;
            put_err_q  <= 1'b0;
            err_q      <= 1'b0;
            drain_q    <= 1'b0;
            rd_cnt_q   <= '0;
            rbuf_q[0]  <= '0;
            rbuf_q[1]  <= '0;
            rerr_q[0]  <= 1'b0;
            rerr_q[1]  <= 1'b0;
        end else begin
            if (rd_take) begin
                rbuf_q[rd_cnt_q[0]] <= rdata_i;
                rerr_q[rd_cnt_q[0]] <= rerror_i;
            end
            rd_cnt_q <= rd_cnt_nxt;
            case (state_q)
                IDLE: if (a.a_valid) begin
                    op_q       <= a.a_opcode;
                    size_q     <= a.a_size;
                    source_q   <= a.a_source;
                    addr_q     <= a.a_address[SramAw+1:2];
                    mask_q     <= a.a_mask;
                    data_q     <= a.a_data;
                    two_q      <= a_two;
                    beat_q     <= 1'b0;
                    resp_idx_q <= 1'b0;
                    rd_cnt_q   <= '0;
                    put_err_q  <= 1'b0;
                    err_q      <= a_bad;
                    drain_q    <= a_bad && a_has_data && a_two;
                    state_q    <= a_bad ? ERR : ISSUE;
                end
                ISSUE: if (gnt_i) begin
                    if (is_put_q) begin
                        // Write errors are reported by the memory alongside gnt_i.
                        put_err_q <= put_err_q | rerror_i;
                        if (two_q && !beat_q) begin
                            beat_q  <= 1'b1;
                            state_q <= PUT2;
                        end else begin
                            state_q <= RESP;
                        end
                    end else if (two_q && !beat_q) begin
                        beat_q <= 1'b1;
                    end else begin
                        state_q <= WAIT_RD;
                    end
                end
                PUT2: if (a.a_valid) begin
                    data_q  <= a.a_data;
                    mask_q  <= a.a_mask;
                    state_q <= ISSUE;
                end
                WAIT_RD: if (rd_cnt_nxt == n_beats) state_q <= RESP;
                ERR: begin
                    if (!drain_q) begin
                        state_q <= RESP;
                    end else if (a.a_valid) begin
                        drain_q <= 1'b0;
                        state_q <= RESP;
                    end
                end
                RESP: if (a.d_ready) begin
                    if (last_resp) state_q <= IDLE;
                    else           resp_idx_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
